// File: rtl/reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_bank
// Description : Two-read / one-write register file with write bypass, a
//               per-register pending (scoreboard) bit and a sequential clear.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bank #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we3,
    input  logic            clr_req,
    output logic            busy,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            pend1,
    output logic            pend2
);

    localparam logic [AW-1:0] c_LAST = AW'(NREG - 1);
    localparam logic [AW-1:0] c_ONE  = AW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;

    logic w_busy;
    logic w_wr;
    logic w_rsv;

    assign w_busy = (r_state == S_CLEAR);
    assign w_wr   = !w_busy && we3 && !((ZERO_REG != 0) && (a3 == '0));
    assign w_rsv  = !w_busy && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    assign busy   = w_busy;
    assign pend1  = r_pend[a1];
    assign pend2  = r_pend[a2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == c_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The sweep zeroes one register per cycle; IDLE traffic is gated off while it runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pend <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_busy) begin
            r_regs[r_cnt] <= '0;
            r_cnt         <= r_cnt + c_ONE;
        end else begin
            if (w_wr) begin
                r_regs[a3] <= wd3;
            end
            if (clr_req) begin
                r_cnt  <= '0;
                r_pend <= '0;
            end else if (w_wr) begin
                r_pend[a3] <= 1'b0;
            end
            // Placed last so a reservation beats a same-cycle write or clear.
            if (w_rsv) begin
                r_pend[rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1 = r_regs[a1];
        if ((BYPASS != 0) && w_wr && (a3 == a1)) rd1 = wd3;
        if (((ZERO_REG != 0) && (a1 == '0)) || w_busy || !rst) rd1 = '0;
    end

    always_comb begin
        rd2 = r_regs[a2];
        if ((BYPASS != 0) && w_wr && (a3 == a2)) rd2 = wd3;
        if (((ZERO_REG != 0) && (a2 == '0)) || w_busy || !rst) rd2 = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_bank
// Description : Scoreboard bench for reg_file_bank (bypass and no-bypass
//               instances driven in parallel against an array model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_bank;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   a1, a2, a3, rsv_addr;
    logic [XLEN-1:0] wd3;
    logic            we3, clr_req, rsv_en;

    logic [XLEN-1:0] rd1, rd2, nb_rd1, nb_rd2;
    logic            busy, pend1, pend2, nb_busy, nb_pend1, nb_pend2;

    always #5 clk = ~clk;

    reg_file_bank #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .a3(a3), .wd3(wd3), .we3(we3), .clr_req(clr_req), .busy(busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend1(pend1), .pend2(pend2)
    );

    reg_file_bank #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(nb_rd1), .rd2(nb_rd2),
        .a3(a3), .wd3(wd3), .we3(we3), .clr_req(clr_req), .busy(nb_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend1(nb_pend1), .pend2(nb_pend2)
    );

    typedef struct {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] nb1;
        logic [XLEN-1:0] nb2;
        logic            pend1;
        logic            pend2;
        logic            busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: register contents, pending flags, clear cycles remaining.
    logic [XLEN-1:0] m_reg [NREG];
    bit              m_pend[NREG];
    int              m_busy_left;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_busy_left = 0;
    endtask

    function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a, input bit byp);
        if (rst !== 1'b1 || m_busy_left > 0 || a == 0) return '0;
        if (byp && we3 && a3 != 0 && a3 == a) return wd3;
        return m_reg[a];
    endfunction

    task automatic model_edge();
        if (m_busy_left > 0) begin
            m_reg[NREG - m_busy_left] = '0;
            m_busy_left--;
        end else begin
            if (we3 && a3 != 0) m_reg[a3] = wd3;
            if (clr_req) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
                m_busy_left = NREG;
            end else if (we3 && a3 != 0) begin
                m_pend[a3] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                        input bit cl, input logic [AW-1:0] x1, input logic [AW-1:0] x2);
        exp_t e;
        rst = r; we3 = w; a3 = wa; wd3 = wd; rsv_en = rv; rsv_addr = ra;
        clr_req = cl; a1 = x1; a2 = x2;
        if (!r) model_reset();
        e.rd1   = model_rd(x1, 1'b1);
        e.rd2   = model_rd(x2, 1'b1);
        e.nb1   = model_rd(x1, 1'b0);
        e.nb2   = model_rd(x2, 1'b0);
        e.pend1 = m_pend[x1];
        e.pend2 = m_pend[x2];
        e.busy  = (m_busy_left > 0);
        sb_q.push_back(e);
        if (r) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_read(input logic [AW-1:0] x1, input logic [AW-1:0] x2);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, x1, x2);
    endtask

    task automatic rnd_step(input bit allow_clr, input bit allow_rst);
        bit r;
        r = !(allow_rst && $urandom_range(0, 99) == 0);
        step(r, ($urandom_range(0, 2) != 0), AW'($urandom_range(0, NREG-1)), $urandom(),
             ($urandom_range(0, 3) == 0), AW'($urandom_range(0, NREG-1)),
             (allow_clr && $urandom_range(0, 39) == 0),
             AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)));
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREG; i++) begin
            step(1'b1, 1'b1, AW'(i), $urandom() | 32'h1, 1'b0, '0, 1'b0, AW'(i), AW'(NREG-i));
        end
    endtask

    task automatic chk(input string n, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rd1",      rd1,             e.rd1);
                chk("rd2",      rd2,             e.rd2);
                chk("nb_rd1",   nb_rd1,          e.nb1);
                chk("nb_rd2",   nb_rd2,          e.nb2);
                chk("pend1",    {31'd0, pend1},  {31'd0, e.pend1});
                chk("pend2",    {31'd0, pend2},  {31'd0, e.pend2});
                chk("busy",     {31'd0, busy},   {31'd0, e.busy});
                chk("nb_busy",  {31'd0, nb_busy}, {31'd0, e.busy});
                chk("nb_pend1", {31'd0, nb_pend1}, {31'd0, e.pend1});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0; rsv_en = 1'b0; rsv_addr = '0;
        clr_req = 1'b0; a1 = '0; a2 = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 5'd9, 5'd1);

        // Basic write then read-back.
        step(1'b1, 1'b1, 5'd9, 32'h0000_0020, 1'b0, '0, 1'b0, 5'd9, 5'd0);
        idle_read(5'd9, 5'd9);

        // Same-cycle forwarding vs. stale read on the no-bypass instance.
        step(1'b1, 1'b1, 5'd5, 32'h1111_2222, 1'b0, '0, 1'b0, 5'd1, 5'd5);
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, 5'd5, 5'd5);
        idle_read(5'd5, 5'd9);

        // Register 0 stays zero and never becomes pending.
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0);

        // Pending flag: set, cleared by write, reservation wins on collision.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd9);
        step(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, 1'b0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);
        step(1'b1, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);

        // Full clear sweep with traffic (and clr_req) thrown at it while busy.
        fill_all();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9, 5'd7);
        for (int i = 0; i < NREG; i++) rnd_step(1'b1, 1'b0);
        for (int i = 0; i < NREG; i++) idle_read(AW'(i), AW'(NREG-1-i));

        // Reset arriving part-way through a sweep.
        fill_all();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd4, 5'd5);
        for (int i = 0; i < 10; i++) rnd_step(1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd2, 32'h5555, 1'b1, 5'd2, 1'b1, 5'd2, 5'd3);
        step(1'b1, 1'b1, 5'd3, 32'hCAFE_0003, 1'b0, '0, 1'b0, 5'd3, 5'd2);
        for (int i = 0; i < NREG; i++) idle_read(AW'(i), AW'(NREG-1-i));

        for (int i = 0; i < 400; i++) rnd_step(1'b1, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 5'd1, 5'd2);

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain act=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
